multiword_add_ctrl: RTL and testbench



---
 rtl/multiword_add_ctrl.sv | 120 ++++++++++++
 tb/tb_multiword_add_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// Wide unsigned adder built from one WIDTH-bit slice reused over WORDS cycles.
// Carry is chained through a register; start/busy/done handshake.
module multiword_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   c_out
);

  localparam int TW = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   a_sr;
  logic [TW-1:0]   b_sr;
  logic [TW-1:0]   res;
  logic [TW-1:0]   res_nxt;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [WIDTH:0]  slice_sum;

  // Shared slice adder: low slice of each operand shift register plus carry.
  always_comb begin
    slice_sum = {1'b0, a_sr[WIDTH-1:0]}
              + {1'b0, b_sr[WIDTH-1:0]}
              + {{WIDTH{1'b0}}, carry};
  end

  // Result with the current slice merged in, so DONE can load it directly.
  always_comb begin
    res_nxt = res;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        res_nxt[i*WIDTH +: WIDTH] = slice_sum[WIDTH-1:0];
      end
    end
  end

  // Sequencer: accept, iterate slices LSB first, publish result for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= slice_sum[WIDTH];
          a_sr  <= a_sr >> WIDTH;
          b_sr  <= b_sr >> WIDTH;
          if (idx == LAST) begin
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_nxt;
            c_out <= slice_sum[WIDTH];
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl: WORDS=4 main instance
// plus a WORDS=1 instance for the degenerate case.
module tb_multiword_add_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        c_out;

  logic        start1 = 1'b0;
  logic [7:0]  a1 = '0;
  logic [7:0]  b1 = '0;
  logic        busy1;
  logic        done1;
  logic [7:0]  sum1;
  logic        c_out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiword_add_ctrl #(.WIDTH(8), .WORDS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  multiword_add_ctrl #(.WIDTH(8), .WORDS(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .c_out (c_out1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", {31'b0, c_out}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: 0xFF + 1, operands change after acceptance
    a = 32'h000000FF; b = 32'h00000001; start = 1'b1;
    tick();
    start = 1'b0; a = 32'hDEADBEEF; b = 32'hCAFEF00D;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t1_busy_c%0d", k), {31'b0, busy}, 32'd1);
      check($sformatf("t1_done_c%0d", k), {31'b0, done}, 32'd0);
      tick();
    end
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_busy_off", {31'b0, busy}, 32'd0);
    check("t1_sum", sum, 32'h00000100);
    check("t1_cout", {31'b0, c_out}, 32'd0);
    tick();
    check("t1_done_pulse", {31'b0, done}, 32'd0);
    check("t1_sum_hold", sum, 32'h00000100);

    // 2: full ripple
    a = 32'hFFFFFFFF; b = 32'h00000001; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t2_done", {31'b0, done}, 32'd1);
    check("t2_sum", sum, 32'h00000000);
    check("t2_cout", {31'b0, c_out}, 32'd1);
    tick();

    // 3: start during RUN ignored
    a = 32'h12345678; b = 32'h11111111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 32'h1; b = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t3_busy_c4", {31'b0, busy}, 32'd1);
    tick();
    check("t3_done", {31'b0, done}, 32'd1);
    check("t3_sum", sum, 32'h23456789);
    check("t3_cout", {31'b0, c_out}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t3_nodone_%0d", k), {31'b0, done}, 32'd0);
      check($sformatf("t3_idle_%0d", k), {31'b0, busy}, 32'd0);
    end

    // 4: back-to-back
    a = 32'h80000000; b = 32'h80000000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t4a_done", {31'b0, done}, 32'd1);
    check("t4a_sum", sum, 32'h0);
    check("t4a_cout", {31'b0, c_out}, 32'd1);
    a = 32'd5; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4b_busy", {31'b0, busy}, 32'd1);
    check("t4b_cout_hold", {31'b0, c_out}, 32'd1);
    repeat (4) tick();
    check("t4b_done", {31'b0, done}, 32'd1);
    check("t4b_sum", sum, 32'h0000000C);
    check("t4b_cout", {31'b0, c_out}, 32'd0);
    tick();

    // 5: reset mid-run
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_sum", sum, 32'h0);
    check("t5_rst_cout", {31'b0, c_out}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t5_nodone_%0d", k), {31'b0, done}, 32'd0);
    end
    a = 32'd1; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_sum", sum, 32'd3);
    check("t5_cout", {31'b0, c_out}, 32'd0);
    tick();

    // 6: WORDS=1
    a1 = 8'hF0; b1 = 8'h20; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1_busy", {31'b0, busy1}, 32'd1);
    check("w1_early", {31'b0, done1}, 32'd0);
    tick();
    check("w1_done", {31'b0, done1}, 32'd1);
    check("w1_sum", {24'b0, sum1}, 32'h10);
    check("w1_cout", {31'b0, c_out1}, 32'd1);
    tick();
    check("w1_pulse", {31'b0, done1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
